// File: rtl/branch_resolve_if.sv
// ID-stage branch resolution bundle: decode inputs, flag sources, redirect
// outputs and statistics counters between the pipeline and branch_resolve.
interface branch_resolve_if;
  logic [31:0] instr_reg_id;
  logic        valid_id;
  logic [63:0] pc_id;
  logic [63:0] data_b_id;
  logic        neg_reg;
  logic        zero_reg;
  logic        overflow_reg;
  logic        carry_out_reg;
  logic        negative;
  logic        zero;
  logic        overflow;
  logic        carry_out;
  logic        flag_en_ex;
  logic        br_taken;
  logic [63:0] br_target;
  logic        flush_if;
  logic        busy;
  logic [31:0] branch_count;
  logic [31:0] taken_count;

  modport master (
    output instr_reg_id, valid_id, pc_id, data_b_id,
    output neg_reg, zero_reg, overflow_reg, carry_out_reg,
    output negative, zero, overflow, carry_out, flag_en_ex,
    input  br_taken, br_target, flush_if, busy, branch_count, taken_count
  );

  modport slave (
    input  instr_reg_id, valid_id, pc_id, data_b_id,
    input  neg_reg, zero_reg, overflow_reg, carry_out_reg,
    input  negative, zero, overflow, carry_out, flag_en_ex,
    output br_taken, br_target, flush_if, busy, branch_count, taken_count
  );
endinterface

// File: rtl/branch_resolve.sv
// Resolves B, B.cond and CBZ in the ID stage and sequences a redirect/flush.
// Statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_resolve (
  input  logic             clk,
  input  logic             reset,
  branch_resolve_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  state_t      state;
  logic        br_taken_q;
  logic        flush_q;
  logic        busy_q;
  logic [63:0] target_q;

  logic        is_b;
  logic        is_bcond;
  logic        is_cbz;
  logic        is_branch;
  logic        taken;
  logic [63:0] offset;
  logic [63:0] target;
  logic        flag_n;
  logic        flag_z;
  logic        flag_c;
  logic        flag_v;
  logic        cond_base;
  logic        cond_taken;
  logic [3:0]  cond;

  // Decode and evaluate; live EX flags win over stored flags when EX writes them.
  always_comb begin
    is_b      = (bus.instr_reg_id[31:26] == 6'b000101);
    is_bcond  = (bus.instr_reg_id[31:24] == 8'b01010100);
    is_cbz    = (bus.instr_reg_id[31:24] == 8'b10110100);
    is_branch = is_b | is_bcond | is_cbz;
    cond      = bus.instr_reg_id[3:0];

    if (is_b)
      offset = {{38{bus.instr_reg_id[25]}}, bus.instr_reg_id[25:0]};
    else
      offset = {{45{bus.instr_reg_id[23]}}, bus.instr_reg_id[23:5]};
    target = bus.pc_id + {offset[61:0], 2'b00};

    flag_n = bus.flag_en_ex ? bus.negative  : bus.neg_reg;
    flag_z = bus.flag_en_ex ? bus.zero      : bus.zero_reg;
    flag_c = bus.flag_en_ex ? bus.carry_out : bus.carry_out_reg;
    flag_v = bus.flag_en_ex ? bus.overflow  : bus.overflow_reg;

    // Odd condition codes are the inverse of the even code below them.
    cond_base = 1'b1;
    case (cond[3:1])
      3'd0:    cond_base = flag_z;
      3'd1:    cond_base = flag_c;
      3'd2:    cond_base = flag_n;
      3'd3:    cond_base = flag_v;
      3'd4:    cond_base = flag_c & ~flag_z;
      3'd5:    cond_base = (flag_n == flag_v);
      3'd6:    cond_base = ~flag_z & (flag_n == flag_v);
      default: cond_base = 1'b1;
    endcase
    cond_taken = (cond[3:1] == 3'd7) ? 1'b1 : (cond_base ^ cond[0]);

    taken = is_b | (is_bcond & cond_taken) | (is_cbz & (bus.data_b_id == 64'h0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      br_taken_q <= 1'b0;
      flush_q    <= 1'b0;
      busy_q     <= 1'b0;
      target_q   <= 64'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.valid_id && taken) begin
            state      <= REDIRECT;
            target_q   <= target;
            br_taken_q <= 1'b1;
            flush_q    <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        REDIRECT: begin
          state      <= FLUSH;
          br_taken_q <= 1'b0;
          flush_q    <= 1'b1;
          busy_q     <= 1'b1;
        end
        FLUSH: begin
          state      <= IDLE;
          br_taken_q <= 1'b0;
          flush_q    <= 1'b0;
          busy_q     <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          br_taken_q <= 1'b0;
          flush_q    <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.br_taken  = br_taken_q;
  assign bus.br_target = target_q;
  assign bus.flush_if  = flush_q;
  assign bus.busy      = busy_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] branch_count_q;
  logic [31:0] taken_count_q;

  // Only IDLE resolves; instructions seen while busy are being squashed.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count_q <= 32'h0;
      taken_count_q  <= 32'h0;
    end else if (state == IDLE && bus.valid_id && is_branch) begin
      if (branch_count_q != 32'hFFFF_FFFF)
        branch_count_q <= branch_count_q + 32'd1;
      if (taken && taken_count_q != 32'hFFFF_FFFF)
        taken_count_q <= taken_count_q + 32'd1;
    end
  end

  assign bus.branch_count = branch_count_q;
  assign bus.taken_count  = taken_count_q;
`else
  assign bus.branch_count = 32'h0;
  assign bus.taken_count  = 32'h0;
`endif

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 The module SHALL use one clock and reset: clk  input  1  rising-edge clock for all state; reset  input  1  reset, synchronous and active-high.
REQ-002 The module SHALL have these ports:
- instr_reg_id  input  32  instruction in the ID stage.
- valid_id  input  1  instr_reg_id holds a live instruction.
- pc_id  input  64  PC of instr_reg_id.
- data_b_id  input  64  Rt operand value for CBZ, already forwarded.
REQ-003 The module SHALL have these flag inputs:
- neg_reg, zero_reg, overflow_reg, carry_out_reg  input  1 each  stored NZVC flags.
- negative, zero, overflow, carry_out  input  1 each  live NZVC flags of the EX instruction.
- flag_en_ex  input  1  the EX instruction updates the flags.
REQ-004 The module SHALL have these outputs:
- br_taken  output  1  registered redirect pulse to the PC mux.
- br_target  output  64  registered redirect address.
- flush_if  output  1  squash the IF/ID register.
- busy  output  1  FSM not IDLE.
REQ-005 The module SHALL have these statistics outputs:
- branch_count  output  32  resolved branches.
- taken_count  output  32  taken branches.

Function
REQ-006 Decode SHALL be:
- B: instr[31:26]=000101, offset = sign-extended imm26 [25:0].
- B.cond: instr[31:24]=01010100, offset = imm19 [23:5], cond = instr[3:0].
- CBZ: instr[31:24]=10110100, offset = imm19 [23:5].
- Any other encoding is not a branch.
REQ-007 The target SHALL be pc_id + (sign-extended offset << 2), computed modulo 2^64.
REQ-008 The taken rules SHALL be: B always taken; CBZ taken iff data_b_id == 0.
REQ-009 For B.cond, the flag source SHALL be the live flags when flag_en_ex=1, otherwise the stored flags.
REQ-010 The B.cond conditions SHALL be:
- EQ 0000: Z; NE 0001: !Z.
- HS 0010: C; LO 0011: !C.
- MI 0100: N; PL 0101: !N.
- VS 0110: V; VC 0111: !V.
- HI 1000: C&!Z; LS 1001: !(C&!Z).
- GE 1010: N==V; LT 1011: N!=V.
- GT 1100: !Z&(N==V); LE 1101: the inverse of GT.
- 1110 and 1111: always taken.
REQ-011 The FSM states SHALL be IDLE, REDIRECT and FLUSH.
REQ-012 In IDLE with valid_id=1 and a taken branch decoded, the FSM SHALL register br_target, set br_taken=1 and go to REDIRECT on the next edge (1-cycle latency).
REQ-013 In IDLE, a not-taken branch or a non-branch instruction SHALL leave the FSM in IDLE with br_taken=0.
REQ-014 In REDIRECT, br_taken=1 and flush_if=1 for exactly one cycle, then the FSM SHALL go to FLUSH.
REQ-015 In FLUSH, br_taken=0 and flush_if=1 for one cycle, then the FSM SHALL go to IDLE.
REQ-016 Branches presented while busy=1 SHALL be ignored: no redirect and no count, because those instructions are squashed.
REQ-017 br_target SHALL hold its last value outside REDIRECT.
REQ-018 busy SHALL be 1 in REDIRECT and FLUSH.
REQ-019 When a flag-setting instruction in EX and a B.cond in ID coincide, the live flags SHALL decide the branch.
REQ-020 branch_count SHALL increment on every branch resolved in IDLE with valid_id=1.
REQ-021 taken_count SHALL increment on every taken branch resolved in IDLE with valid_id=1.
REQ-022 Both counters SHALL saturate at 32'hFFFF_FFFF.

Reset
REQ-023 On reset=1 at a clock edge, the FSM SHALL go to IDLE and br_taken, flush_if and busy SHALL be 0.
REQ-024 On reset=1 at a clock edge, br_target SHALL be 64'h0 and both counters 0.
REQ-025 Reset asserted during REDIRECT or FLUSH SHALL abandon the redirect with no further flush cycle.

Configuration
REQ-026 Macro BRANCH_STATS_EN SHALL control the statistics counters.
REQ-027 With BRANCH_STATS_EN defined, the module SHALL implement both counters per REQ-020 to REQ-022.
REQ-028 Without BRANCH_STATS_EN, the counter ports SHALL remain and be tied to 32'h0, with no counter flops.

Verification
REQ-029 The bench SHALL cover:
- B, pc_id=64'h100, imm26=3 -> br_taken=1 and br_target=64'h10C one cycle later; flush_if high 2 cycles; busy 2 cycles.
- B.cond EQ, zero_reg=1, flag_en_ex=0 -> taken; same with flag_en_ex=1, zero=0 -> not taken; branch_count=2, taken_count=1.
- CBZ, imm19=-2 (7FFFE), pc_id=64'h40, data_b_id=0 -> br_target=64'h38; data_b_id=5 -> no redirect.
- B.cond GE/LT/GT/LE swept over all 16 NZVC combinations -> br_taken matches REQ-010.
- Taken B, then a second B presented during REDIRECT -> a single redirect; branch_count=1.
- Reset asserted in REDIRECT -> next cycle flush_if=0, busy=0, counters 0; counters preloaded to 32'hFFFF_FFFF stay saturated on a further taken branch.
